// File: rtl/md5_block_sched_if.sv
// rtl/md5_block_sched_if.sv - message stream, core control and digest bundle for md5_block_sched
interface md5_block_sched_if;
  logic [31:0]  in_word;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic         core_en1;
  logic         core_en2;
  logic         core_en3;
  logic         core_en4;
  logic [127:0] core_data;
  logic [127:0] core_iv;
  logic         core_start;
  logic         core_done;
  logic [127:0] core_digest;
  logic [127:0] dig_o;
  logic         dig_valid;
  logic         dig_ready;
  logic         busy;
  logic         err_timeout;
  logic         err_clr;

  modport master (
    output in_word, in_valid, in_last, core_done, core_digest, dig_ready, err_clr,
    input  in_ready, core_en1, core_en2, core_en3, core_en4, core_data, core_iv,
           core_start, dig_o, dig_valid, busy, err_timeout
  );

  modport slave (
    input  in_word, in_valid, in_last, core_done, core_digest, dig_ready, err_clr,
    output in_ready, core_en1, core_en2, core_en3, core_en4, core_data, core_iv,
           core_start, dig_o, dig_valid, busy, err_timeout
  );
endinterface

// File: rtl/md5_block_sched.sv
// rtl/md5_block_sched.sv - MD5 block sequencer: packs 16 words, loads/starts the core, chains digests
module md5_block_sched #(
  parameter logic [127:0] IV      = 128'h67452301_efcdab89_98badcfe_10325476,
  parameter int           TIMEOUT = 96,
  parameter int           CNT_W   = 7
) (
  input logic              clk,
  input logic              reset,
  md5_block_sched_if.slave bus
);
  localparam logic [2:0] S_COLLECT = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_START   = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_OUTPUT  = 3'd4;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [3:0]       wcnt_q, wcnt_d;
  logic [1:0]       ld_q, ld_d;
  logic [511:0]     blk_q, blk_d;
  logic [127:0]     chain_q, chain_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [127:0]     dig_q, dig_d;
  logic             dig_valid_q, dig_valid_d;
  logic             err_q, err_d;
  logic             timeout_hit;

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    ld_d        = ld_q;
    blk_d       = blk_q;
    chain_d     = chain_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    dig_d       = dig_q;
    dig_valid_d = dig_valid_q;
    timeout_hit = 1'b0;
    case (state_q)
      S_COLLECT: begin
        if (bus.in_valid) begin
          blk_d[9'd511 - {wcnt_q, 5'd0} -: 32] = bus.in_word;
          wcnt_d = wcnt_q + 4'd1;
          if (wcnt_q == 4'd15) begin
            last_d  = bus.in_last;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        ld_d = ld_q + 2'd1;
        if (ld_q == 2'd3) state_d = S_START;
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A completion in the timeout cycle still counts as success.
        if (bus.core_done) begin
          chain_d = bus.core_digest;
          if (last_q) begin
            dig_d       = bus.core_digest;
            dig_valid_d = 1'b1;
            state_d     = S_OUTPUT;
          end else begin
            state_d = S_COLLECT;
          end
        end else if (cnt_q == CNT_LAST) begin
          timeout_hit = 1'b1;
          chain_d     = IV;
          last_d      = 1'b0;
          state_d     = S_COLLECT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_OUTPUT: begin
        if (bus.dig_ready) begin
          dig_valid_d = 1'b0;
          chain_d     = IV;
          state_d     = S_COLLECT;
        end
      end
      default: state_d = S_COLLECT;
    endcase
    err_d = err_q;
    if (bus.err_clr) err_d = 1'b0;
    if (timeout_hit) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_COLLECT;
      wcnt_q      <= '0;
      ld_q        <= '0;
      blk_q       <= '0;
      chain_q     <= IV;
      last_q      <= 1'b0;
      cnt_q       <= '0;
      dig_q       <= '0;
      dig_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      ld_q        <= ld_d;
      blk_q       <= blk_d;
      chain_q     <= chain_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      dig_q       <= dig_d;
      dig_valid_q <= dig_valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready    = (state_q == S_COLLECT);
  assign bus.busy        = (state_q != S_COLLECT);
  assign bus.core_en1    = (state_q == S_LOAD) && (ld_q == 2'd0);
  assign bus.core_en2    = (state_q == S_LOAD) && (ld_q == 2'd1);
  assign bus.core_en3    = (state_q == S_LOAD) && (ld_q == 2'd2);
  assign bus.core_en4    = (state_q == S_LOAD) && (ld_q == 2'd3);
  assign bus.core_data   = (state_q == S_LOAD) ? blk_q[9'd511 - {ld_q, 7'd0} -: 128] : '0;
  assign bus.core_start  = (state_q == S_START);
  assign bus.core_iv     = chain_q;
  assign bus.dig_o       = dig_q;
  assign bus.dig_valid   = dig_valid_q;
  assign bus.err_timeout = err_q;
endmodule

// File: tb/tb_md5_block_sched.sv
// tb/tb_md5_block_sched.sv - table-driven and scoreboard bench for md5_block_sched
module tb_md5_block_sched;
  localparam logic [127:0] IV      = 128'h67452301_efcdab89_98badcfe_10325476;
  localparam int           TIMEOUT = 96;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  md5_block_sched_if bus ();
  md5_block_sched #(.IV(IV), .TIMEOUT(TIMEOUT), .CNT_W(7)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic         model_done  = 1'b0;
  logic         extra_done  = 1'b0;
  logic         model_never = 1'b0;
  logic [127:0] model_digest = '0;
  int           model_delay = 64;
  int           model_cnt   = 0;
  assign bus.core_done   = model_done | extra_done;
  assign bus.core_digest = model_digest;

  int           n_chk = 0;
  int           n_err = 0;
  logic [127:0] sb_q[$];

  typedef struct {
    logic [31:0]  base;
    logic         last;
    logic         bp;
    int           delay;
    logic [127:0] digest;
    logic [127:0] exp_iv;
    logic [127:0] exp_en1;
    int           ready_wait;
  } vec_t;
  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chkv(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  function automatic logic [127:0] strobes();
    return 128'({bus.core_en1, bus.core_en2, bus.core_en3, bus.core_en4, bus.core_start});
  endfunction

  // Core model: done pulse model_delay cycles after the start cycle.
  initial forever begin
    @(negedge clk);
    model_done = 1'b0;
    if (model_cnt > 0) begin
      model_cnt--;
      if (model_cnt == 0) model_done = 1'b1;
    end
    if (bus.core_start && !model_never) model_cnt = model_delay;
  end

  // Scoreboard consumer: compare on every output handshake.
  initial forever begin
    @(negedge clk);
    if (bus.dig_valid && bus.dig_ready) begin
      n_chk++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got %h want no digest", bus.dig_o);
      end else begin
        logic [127:0] e;
        e = sb_q.pop_front();
        if (bus.dig_o !== e) begin
          n_err++;
          $display("FAIL sb_digest: got %h want %h", bus.dig_o, e);
        end
      end
    end
  end

  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: got timeout want finish");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1);
  end

  task automatic send_words(input logic [31:0] base, input logic last, input logic bp);
    int n;
    n = 0;
    while (!bus.in_ready && n < 300) begin tick(); n++; end
    chk1("collect_ready", bus.in_ready, 1'b1);
    for (int i = 0; i < 16; i++) begin
      if (bp) begin
        bus.in_valid = 1'b0;
        bus.in_word  = 32'hffff_ffff;
        tick();
        chk1("bp_in_ready", bus.in_ready, 1'b1);
      end
      bus.in_valid = 1'b1;
      bus.in_word  = base + 32'(i);
      bus.in_last  = (i == 15) ? last : (i == 7);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic check_load(input logic [31:0] base, input logic [127:0] exp_iv, input logic [127:0] exp_en1);
    for (int k = 0; k < 4; k++) begin
      logic [127:0] exp_d;
      exp_d = {base + 32'(4*k), base + 32'(4*k+1), base + 32'(4*k+2), base + 32'(4*k+3)};
      chkv("load_strobes", strobes(), 128'(5'b10000 >> k));
      chkv("load_data", bus.core_data, exp_d);
      chk1("load_in_ready", bus.in_ready, 1'b0);
      if (k == 0) begin
        chkv("en1_data", bus.core_data, exp_en1);
        chkv("load_core_iv", bus.core_iv, exp_iv);
      end
      tick();
    end
    chkv("start_pulse", strobes(), 128'h1);
    chkv("start_data_zero", bus.core_data, '0);
    tick();
    chkv("wait_entry", strobes(), '0);
    chkv("wait_core_iv", bus.core_iv, exp_iv);
  endtask

  task automatic run_block(input vec_t v);
    int   n;
    logic early;
    model_digest = v.digest;
    model_delay  = v.delay;
    model_never  = 1'b0;
    if (v.last) sb_q.push_back(v.digest);
    send_words(v.base, v.last, v.bp);
    check_load(v.base, v.exp_iv, v.exp_en1);
    n = 0;
    early = 1'b0;
    while (!bus.core_done && n < 300) begin
      if (bus.dig_valid) early = 1'b1;
      tick();
      n++;
    end
    chk1("done_seen", n < 300, 1'b1);
    chk1("no_early_valid", early, 1'b0);
    chk1("err_after_done", bus.err_timeout, 1'b0);
    if (v.last) begin
      chk1("dig_valid_rise", bus.dig_valid, 1'b1);
      for (int c = 0; c < v.ready_wait; c++) begin
        chk1("hold_valid", bus.dig_valid, 1'b1);
        chkv("hold_dig", bus.dig_o, v.digest);
        chk1("hold_in_ready", bus.in_ready, 1'b0);
        tick();
      end
      bus.dig_ready = 1'b1;
      tick();
      bus.dig_ready = 1'b0;
      chk1("post_hs_valid", bus.dig_valid, 1'b0);
      chk1("post_hs_in_ready", bus.in_ready, 1'b1);
      chkv("post_hs_iv", bus.core_iv, IV);
    end else begin
      chk1("chain_no_valid", bus.dig_valid, 1'b0);
      chk1("chain_in_ready", bus.in_ready, 1'b1);
      chkv("chain_iv", bus.core_iv, v.digest);
    end
  endtask

  initial begin
    vecs[0] = '{32'h0000_0000, 1'b1, 1'b0, 64, {4{32'haaaa_aaaa}}, IV,
                128'h00000000_00000001_00000002_00000003, 0};
    vecs[1] = '{32'h0000_0010, 1'b0, 1'b1, 64, {4{32'h1111_1111}}, IV,
                128'h00000010_00000011_00000012_00000013, 0};
    vecs[2] = '{32'h0000_0020, 1'b1, 1'b0, 64, {4{32'h2222_2222}}, {4{32'h1111_1111}},
                128'h00000020_00000021_00000022_00000023, 10};
    vecs[3] = '{32'hdead_0000, 1'b1, 1'b1, 40, 128'h01234567_89abcdef_fedcba98_76543210, IV,
                128'hdead0000_dead0001_dead0002_dead0003, 3};
    vecs[4] = '{32'h0000_0030, 1'b0, 1'b0, 64, {4{32'h7777_7777}}, IV,
                128'h00000030_00000031_00000032_00000033, 0};
    vecs[5] = '{32'h0000_0040, 1'b1, 1'b0, TIMEOUT, {4{32'h4444_4444}}, IV,
                128'h00000040_00000041_00000042_00000043, 0};
    vecs[6] = '{32'h0000_0050, 1'b0, 1'b0, 64, {4{32'h5555_5555}}, IV,
                128'h00000050_00000051_00000052_00000053, 0};

    bus.in_word   = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.dig_ready = 1'b0;
    bus.err_clr   = 1'b0;
    tick();
    tick();
    chk1("rst_in_ready", bus.in_ready, 1'b1);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_dig_valid", bus.dig_valid, 1'b0);
    chk1("rst_err", bus.err_timeout, 1'b0);
    chkv("rst_strobes", strobes(), '0);
    chkv("rst_core_data", bus.core_data, '0);
    chkv("rst_core_iv", bus.core_iv, IV);
    chkv("rst_dig_o", bus.dig_o, '0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) run_block(vecs[i]);

    // Timeout with a non-IV chain, then clear and recover.
    run_block(vecs[4]);
    model_never  = 1'b1;
    model_digest = {4{32'hbad0_bad0}};
    send_words(32'h0000_3000, 1'b1, 1'b0);
    check_load(32'h0000_3000, {4{32'h7777_7777}}, 128'h00003000_00003001_00003002_00003003);
    repeat (TIMEOUT - 1) tick();
    chk1("pre_timeout_err", bus.err_timeout, 1'b0);
    chk1("pre_timeout_busy", bus.busy, 1'b1);
    tick();
    chk1("timeout_err", bus.err_timeout, 1'b1);
    chk1("timeout_in_ready", bus.in_ready, 1'b1);
    chk1("timeout_no_valid", bus.dig_valid, 1'b0);
    chkv("timeout_iv", bus.core_iv, IV);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk1("err_cleared", bus.err_timeout, 1'b0);
    model_never = 1'b0;

    // core_done lands on the timeout cycle.
    run_block(vecs[5]);

    // Stray core_done while collecting.
    model_digest = {4{32'hdead_beef}};
    extra_done = 1'b1;
    tick();
    extra_done = 1'b0;
    chk1("stray_in_ready", bus.in_ready, 1'b1);
    chk1("stray_busy", bus.busy, 1'b0);
    chk1("stray_valid", bus.dig_valid, 1'b0);
    chkv("stray_iv", bus.core_iv, IV);

    // Asynchronous reset in the middle of LOAD with a chained IV.
    run_block(vecs[6]);
    send_words(32'h0000_6000, 1'b0, 1'b0);
    chk1("pre_rst_en1", bus.core_en1, 1'b1);
    tick();
    chk1("pre_rst_en2", bus.core_en2, 1'b1);
    #2 reset = 1'b0;
    #1;
    chkv("arst_strobes", strobes(), '0);
    chkv("arst_data", bus.core_data, '0);
    chk1("arst_in_ready", bus.in_ready, 1'b1);
    chk1("arst_busy", bus.busy, 1'b0);
    chkv("arst_iv", bus.core_iv, IV);
    @(negedge clk);
    reset = 1'b1;
    tick();
    run_block(vecs[0]);

    chkv("sb_drained", 128'(sb_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/md5_block_sched.md
Name: md5_block_sched

Overview:
- Sequencing controller for the MD5 compression core.
- Accepts the message as a stream of 32-bit words over a valid/ready handshake and packs 16 words into a 512-bit block.
- Drives the core's four 128-bit load strobes, starts the compression, and waits for completion under a timeout.
- Chains digests across multi-block messages and presents the final 128-bit digest on a valid/ready output handshake.

Parameters:
- IV, 128'h67452301_efcdab89_98badcfe_10325476: initial chaining value (A,B,C,D from MSB).
- TIMEOUT, 96: maximum cycles spent in WAIT before abort; legal range 2..(2^CNT_W - 1).
- CNT_W, 7: width of the WAIT cycle counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_word  in  32  message word.
- in_valid  in  1  in_word is valid.
- in_last  in  1  current block is the final block of the message; sampled only with word 15.
- in_ready  out  1  controller accepts a word this cycle.
- core_en1..core_en4  out  1 each  load strobes for core block bits [511:384], [383:256], [255:128], [127:0].
- core_data  out  128  load data accompanying the active strobe.
- core_iv  out  128  chaining value for the core; held stable from the core_en1 cycle through the end of WAIT.
- core_start  out  1  single-cycle start pulse.
- core_done  in  1  core finished; core_digest is valid in the same cycle.
- core_digest  in  128  IV + compression result.
- dig_o  out  128  final message digest.
- dig_valid  out  1  dig_o is valid.
- dig_ready  in  1  consumer accepts dig_o.
- busy  out  1  high in every state except COLLECT.
- err_timeout  out  1  sticky timeout flag.
- err_clr  in  1  clears err_timeout.

Behaviour:
- Reset (reset=0, asynchronous):
  - State=COLLECT, word count=0, block buffer=0, chain=IV, last flag=0.
  - WAIT counter=0, dig_o=0, dig_valid=0, err_timeout=0, all core strobes and core_start=0.
  - in_ready=1 and busy=0, because both are decoded from state.
- States: COLLECT, LOAD, START, WAIT, OUTPUT.
- COLLECT:
  - in_ready=1; a word is accepted when in_valid && in_ready.
  - Word i (0..15) is written to buffer bits [511-32i -: 32], so word 0 occupies the MSBs.
  - in_last is latched on word 15; the word count wraps 15->0 and the state moves to LOAD.
- LOAD: 4 cycles.
  - Cycle k (k=0..3) asserts exactly one strobe, core_en(k+1), with core_data = buffer[511-128k -: 128].
  - core_data=0 whenever no strobe is asserted.
- START: core_start=1 for exactly one cycle, then WAIT with the counter cleared.
- WAIT: the counter increments each cycle.
  - On core_done: chain <= core_digest.
    - If the last flag=1: dig_o <= core_digest, dig_valid<=1, state->OUTPUT.
    - If the last flag=0: state->COLLECT.
  - On counter == TIMEOUT-1 without core_done: err_timeout<=1, chain<=IV, last flag<=0, state->COLLECT, no digest produced.
  - If core_done and the timeout coincide in the same cycle, core_done wins.
- OUTPUT:
  - dig_o and dig_valid are held stable until dig_valid && dig_ready.
  - On that handshake: dig_valid<=0, chain<=IV, state->COLLECT.
  - in_ready=0 throughout OUTPUT; there is no overlap with the next message.
- core_iv = chain register at all times.
- core_done outside WAIT is ignored.
- err_clr clears err_timeout the following cycle.
  - If err_clr coincides with a new timeout, the flag stays set.
  - err_timeout does not block operation.
- Latency:
  - Word 15 accepted at cycle T gives core_en1 at T+1, core_en4 at T+4, core_start at T+5, WAIT from T+6.
  - core_done at cycle D gives dig_valid=1 at D+1.
- Reset asserted mid-operation aborts everything immediately; the partial block and the chain are discarded.
- All arithmetic is unsigned. The WAIT counter is CNT_W bits and is never allowed to wrap.

Test Plan:
- Single block: reset; stream 16 words 0x00000000..0x0000000F with in_last=1 on word 15 -> core_en1..4 on consecutive cycles, core_en1 data 0x00000000_00000001_00000002_00000003, core_iv=IV, one core_start pulse; model returns done after 64 cycles with digest 0xAA..AA -> dig_valid next cycle, dig_o=0xAA..AA.
- Two-block chain: first block in_last=0, model digest 0x1111..11 -> core_iv=0x1111..11 during the second block's LOAD; second done -> dig_o=second digest; after dig_ready the chain returns to IV.
- Backpressure: in_valid toggled every other cycle during COLLECT -> exactly 16 accepted words per block, buffer order correct; dig_ready held low 10 cycles -> dig_o/dig_valid stable, in_ready=0 throughout.
- Timeout: model never asserts core_done -> err_timeout=1 exactly TIMEOUT cycles after WAIT entry, no dig_valid, in_ready=1 next cycle; err_clr pulse -> err_timeout=0; a following block completes normally with core_iv=IV.
- Boundary: core_done in the same cycle as the timeout -> digest accepted, err_timeout stays 0; core_done pulsed during COLLECT -> no effect.
- Async reset mid-LOAD (after core_en2) -> all strobes drop immediately, in_ready=1, busy=0, chain=IV.
